// File: rtl/uart2ahb_pkg.sv
// uart2ahb shared types and constants.
// Receiver FSM state encoding and default frame geometry.
package uart2ahb_pkg;

  localparam int UART_OVS    = 16;
  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Serial line 2-flop synchronizer and falling-edge detector.
// Flops reset to 1 so an idle line never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic ser_in,
  output logic rxd,
  output logic fall
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= ser_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rxd  = s2_q;
  assign fall = prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN).
// Majority-voted bits, valid/ready output with framing/parity/overrun.
module uart_rx
  import uart2ahb_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int OVS    = UART_OVS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              baud_tick,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              par_err,
  output logic              overrun,
  output logic              busy
);

  localparam int OSW = $clog2(OVS);
  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [OSW-1:0] S0   = OSW'(OVS/2 - 1);
  localparam logic [OSW-1:0] S1   = OSW'(OVS/2);
  localparam logic [OSW-1:0] S2   = OSW'(OVS/2 + 1);
  localparam logic [BCW-1:0] LAST = BCW'(DATA_W - 1);

  logic rxd;
  logic fall;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .ser_in (ser_in),
    .rxd    (rxd),
    .fall   (fall)
  );

  uart_rx_state_e    state_q;
  logic [OSW-1:0]    os_cnt_q;
  logic [BCW-1:0]    bit_cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic              samp0_q;
  logic              samp1_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic              busy_q;

  logic [OSW-1:0]    os_d;
  logic              vote_d;
  logic              wrap_d;
  logic              decide_d;
  logic              perr_d;

  // Counter value this tick advances to; votes key off it so the
  // decision lands OVS/2+1 ticks into each bit.
  assign os_d     = os_cnt_q + 1'b1;
  assign vote_d   = (samp0_q & samp1_q) | (samp0_q & rxd) | (samp1_q & rxd);
  assign wrap_d   = baud_tick && (os_d == '0);
  assign decide_d = baud_tick && (os_d == S2);

`ifdef UART_RX_PARITY_EN
  logic par_bit_q;
  logic par_err_q;
  assign perr_d  = (^shreg_q) ^ par_bit_q;
  assign par_err = par_err_q;
`else
  assign perr_d  = 1'b0;
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      samp0_q     <= 1'b1;
      samp1_q     <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
      if (baud_tick && state_q != IDLE) begin
        os_cnt_q <= os_d;
        if (os_d == S0) samp0_q <= rxd;
        if (os_d == S1) samp1_q <= rxd;
      end
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q  <= START;
            os_cnt_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (decide_d && vote_d) begin
            state_q  <= IDLE;
            os_cnt_q <= '0;
            busy_q   <= 1'b0;
          end else if (wrap_d) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (decide_d) shreg_q <= {vote_d, shreg_q[DATA_W-1:1]};
          if (wrap_d) begin
            if (bit_cnt_q == LAST) begin
              bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
              state_q   <= PARITY;
`else
              state_q   <= STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (decide_d) par_bit_q <= vote_d;
          if (wrap_d) state_q <= STOP;
        end
`endif
        // Leave at the vote so a back-to-back start edge is not missed.
        STOP: begin
          if (decide_d) begin
            state_q  <= IDLE;
            os_cnt_q <= '0;
            busy_q   <= 1'b0;
            if (!rx_valid_q || rx_ready) begin
              rx_data_q   <= shreg_q;
              frame_err_q <= ~vote_d;
              rx_valid_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
              par_err_q   <= perr_d;
`endif
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

  logic unused_perr;
  assign unused_perr = perr_d;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames driven tick by tick,
// received characters collected by a monitor and compared in order.
module tb_uart_rx;

  localparam int OVS = 16;
  localparam int TP  = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_in;
  logic       baud_tick;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       par_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;
  int v0;

  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [9:0] e;
  logic [9:0] g;

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .baud_tick (baud_tick),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .par_err   (par_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (TP - 1) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (rx_valid) vcnt++;
    if (rx_valid && rx_ready)
      got_q.push_back({par_err, frame_err, rx_data});
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish, got=timeout need=finish");
    $fatal(1);
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
  endtask

  task automatic seg(input logic v, input int n);
    @(negedge clk);
    ser_in = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic sv,
                            input int sn, input int gb, input int gt,
                            input logic pinv);
    seg(1'b0, OVS);
    for (int i = 0; i < 8; i++) begin
      if (i == gb) begin
        seg(d[i], gt - 1);
        seg(~d[i], 1);
        seg(d[i], OVS - gt);
      end else begin
        seg(d[i], OVS);
      end
    end
    if (PAR) seg((^d) ^ pinv, OVS);
    seg(sv, sn);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      ser_in = ~ser_in;
    end
    #1;
    checks++;
    if ({rx_valid, rx_data, frame_err, par_err, overrun} !== 12'h0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h fe=%b pe=%b ov=%b need all 0",
               rx_valid, rx_data, frame_err, par_err, overrun);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got %b need 0", busy);
    end
    @(negedge clk);
    ser_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rx_ready = 1'b1;
    v0 = vcnt;
    wait_ticks(1);
    exp_q.push_back({2'b00, 8'hA5});
    send_frame(8'hA5, 1'b1, OVS, -1, 0, 1'b0);
    seg(1'b1, 4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++;
        $display("FAIL a5_rx got none need %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL a5_rx got %h need %h", g, e);
        end
      end
    end
    checks++;
    if (vcnt - v0 != 1) begin
      failures++;
      $display("FAIL a5_pulse got %0d valid cycles need 1", vcnt - v0);
    end
  endtask

  task automatic test_glitch;
    wait_ticks(1);
    seg(1'b0, 4);
    seg(1'b1, 5);
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_busy got %b need 0", busy);
    end
    seg(1'b1, 2 * OVS);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL glitch_none got %0d chars need 0", got_q.size());
    end
    got_q.delete();
    exp_q.push_back({2'b00, 8'h3C});
    send_frame(8'h3C, 1'b1, OVS, 2, 8, 1'b0);
    seg(1'b1, 4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++;
        $display("FAIL glitch_3c got none need %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL glitch_3c got %h need %h", g, e);
        end
      end
    end
  endtask

  task automatic test_framing;
    exp_q.push_back({2'b01, 8'h55});
    send_frame(8'h55, 1'b0, OVS, -1, 0, 1'b0);
    seg(1'b1, 4);
    exp_q.push_back({2'b01, 8'h00});
    seg(1'b0, 20 * OVS);
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL break_busy got %b need 0", busy);
    end
    seg(1'b1, OVS);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++;
        $display("FAIL framing got none need %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL framing got %h need %h", g, e);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL break_extra got %0d extra chars need 0", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_overrun;
    @(negedge clk);
    rx_ready = 1'b0;
    wait_ticks(1);
    exp_q.push_back({2'b00, 8'h11});
    send_frame(8'h11, 1'b1, OVS, -1, 0, 1'b0);
    send_frame(8'h22, 1'b1, OVS, -1, 0, 1'b0);
    seg(1'b1, 4);
    @(negedge clk);
    #1;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      failures++;
      $display("FAIL ovr_hold got v=%b d=%h need v=1 d=11", rx_valid, rx_data);
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_flag got %b need 1", overrun);
    end
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    #1;
    checks++;
    if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear got v=%b ov=%b need 0 0", rx_valid, overrun);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++;
        $display("FAIL ovr_rx got none need %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL ovr_rx got %h need %h", g, e);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL ovr_extra got %0d extra chars need 0", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    bytes[0] = 8'h01;
    bytes[1] = 8'h80;
    bytes[2] = 8'hFF;
    @(negedge clk);
    rx_ready = 1'b1;
    wait_ticks(1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'b00, bytes[i]});
      send_frame(bytes[i], 1'b1, OVS/2 + 2, -1, 0, 1'b0);
    end
    seg(1'b1, OVS);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++;
        $display("FAIL b2b got none need %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL b2b got %h need %h", g, e);
        end
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    wait_ticks(1);
    exp_q.push_back({2'b00, 8'h07});
    send_frame(8'h07, 1'b1, OVS, -1, 0, 1'b0);
    exp_q.push_back({2'b10, 8'h07});
    send_frame(8'h07, 1'b1, OVS, -1, 0, 1'b1);
    seg(1'b1, 4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++;
        $display("FAIL parity got none need %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL parity got %h need %h", g, e);
        end
      end
    end
  endtask
`endif

  task automatic test_abort;
    logic [7:0] d;
    d = 8'h5A;
    wait_ticks(1);
    seg(1'b0, OVS);
    for (int i = 0; i < 7; i++) seg(d[i], OVS);
    if (PAR) begin
      seg(d[7], OVS);
      seg(^d, OVS/2);
    end else begin
      seg(d[7], OVS/2);
    end
    @(negedge clk);
    rst = 1'b1;
    ser_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset got busy=%b v=%b need 0 0", busy, rx_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    seg(1'b1, 3 * OVS);
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || got_q.size() != 0) begin
      failures++;
      $display("FAIL abort_idle got busy=%b chars=%0d need 0 0",
               busy, got_q.size());
    end
    got_q.delete();
  endtask

  initial begin
    ser_in   = 1'b1;
    rst      = 1'b1;
    rx_ready = 1'b0;
    test_reset();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
